// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for a small ARM-like core.
// Sequences FETCH/DECODE/memory/execute/branch states and drives the datapath
// selects and write enables. It also holds the architectural NZCV flags.
//
// Parameters:
//   ALU_CTRL_W : ALUControl width (2 or 3). EOR and CMP exist only at 3.
//   RD_W       : destination register field width. All-ones selects the PC.
//
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   Op, Funct, Rd     : instruction class, {I, cmd[3:0], S/L}, destination
//   Cond              : condition field
//   ALUFlags          : NZCV from the ALU, captured in execute states
//   mem_ready         : memory handshake; low stalls the memory states
//   PCWrite, IRWrite, MemW, RegW : write enables, forced low during reset
//   AdrSrc, ALUSrcA, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl : datapath selects
//   illegal           : one-cycle pulse in DECODE for an undefined instruction
//   Flags             : architectural NZCV register
//
// Optional build macro: MC_COND_EXEC_EN enables conditional execution from Cond.
module mc_controller #(
   parameter int unsigned ALU_CTRL_W = 3,
   parameter int unsigned RD_W       = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            Op,
   input  logic [5:0]            Funct,
   input  logic [RD_W-1:0]       Rd,
   input  logic [3:0]            Cond,
   input  logic [3:0]            ALUFlags,
   input  logic                  mem_ready,
   output logic                  PCWrite,
   output logic                  IRWrite,
   output logic                  MemW,
   output logic                  RegW,
   output logic                  AdrSrc,
   output logic                  ALUSrcA,
   output logic                  illegal,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ImmSrc,
   output logic [1:0]            RegSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic [3:0]            Flags
);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;
   localparam bit         EXT_OPS = (ALU_CTRL_W >= 3);

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] flags_q, flags_d;

   logic [3:0] cmd;
   logic       s_bit, imm_bit, rd_is_pc;
   logic       cmd_legal, cmd_arith, is_cmp;
   logic [2:0] alu_exec;
   logic       cond_ok;
   logic       pc_we, ir_we, mem_we, reg_we;

   assign cmd      = Funct[4:1];
   assign imm_bit  = Funct[5];
   assign s_bit    = Funct[0];
   assign rd_is_pc = (Rd == '1);
   assign is_cmp   = EXT_OPS && (cmd == CMD_CMP);

   // Data-processing command decode: legality, ALU opcode, CV-affecting ops
   always_comb begin
      cmd_legal = 1'b1;
      cmd_arith = 1'b0;
      alu_exec  = ALU_ADD;
      case (cmd)
         CMD_ADD: begin alu_exec = ALU_ADD; cmd_arith = 1'b1; end
         CMD_SUB: begin alu_exec = ALU_SUB; cmd_arith = 1'b1; end
         CMD_AND: alu_exec = ALU_AND;
         CMD_ORR: alu_exec = ALU_ORR;
         CMD_EOR: begin alu_exec = ALU_EOR; cmd_legal = EXT_OPS; end
         CMD_CMP: begin alu_exec = ALU_SUB; cmd_arith = 1'b1; cmd_legal = EXT_OPS; end
         default: cmd_legal = 1'b0;
      endcase
   end

`ifdef MC_COND_EXEC_EN
   // Standard condition table evaluated against the architectural flags
   logic fn, fz, fc, fv;
   assign {fn, fz, fc, fv} = flags_q;

   always_comb begin
      cond_ok = 1'b1;
      case (Cond)
         4'b0000: cond_ok = fz;
         4'b0001: cond_ok = !fz;
         4'b0010: cond_ok = fc;
         4'b0011: cond_ok = !fc;
         4'b0100: cond_ok = fn;
         4'b0101: cond_ok = !fn;
         4'b0110: cond_ok = fv;
         4'b0111: cond_ok = !fv;
         4'b1000: cond_ok = fc && !fz;
         4'b1001: cond_ok = !fc || fz;
         4'b1010: cond_ok = (fn == fv);
         4'b1011: cond_ok = (fn != fv);
         4'b1100: cond_ok = !fz && (fn == fv);
         4'b1101: cond_ok = fz || (fn != fv);
         default: cond_ok = 1'b1;
      endcase
   end
`else
   // Unconditional build: Cond is referenced but cannot affect the result
   assign cond_ok = 1'b1 | (^Cond);
`endif

   // State and flag registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= FETCH;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   // Flags move only in execute; CMP writes flags even without S
   always_comb begin
      flags_d = flags_q;
      if ((state_q == EXECR || state_q == EXECI) && (s_bit || is_cmp)) begin
         flags_d[3:2] = ALUFlags[3:2];
         if (cmd_arith) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   // Next-state and per-state datapath controls
   always_comb begin
      state_d    = state_q;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      illegal    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
      ALUControl = ALU_CTRL_W'(ALU_ADD);
      case (state_q)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ImmSrc    = Op;
            RegSrc    = {Op == 2'b01, Op == 2'b10};
            if (!cond_ok) begin
               state_d = FETCH;
            end else begin
               case (Op)
                  2'b01: state_d = MEMADR;
                  2'b00: begin
                     if (!cmd_legal) begin
                        illegal = 1'b1;
                        state_d = FETCH;
                     end else begin
                        state_d = imm_bit ? EXECI : EXECR;
                     end
                  end
                  2'b10: state_d = BRANCH;
                  default: begin
                     illegal = 1'b1;
                     state_d = FETCH;
                  end
               endcase
            end
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            state_d = s_bit ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_we    = 1'b1;
            pc_we     = rd_is_pc;
            state_d   = FETCH;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            mem_we = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXECR, EXECI: begin
            ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
            ALUControl = ALU_CTRL_W'(alu_exec);
            state_d    = is_cmp ? FETCH : ALUWB;
         end
         ALUWB: begin
            reg_we  = 1'b1;
            pc_we   = rd_is_pc;
            state_d = FETCH;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            pc_we     = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Write enables are held off while reset is asserted, even mid-stall
   assign PCWrite = pc_we  & reset_n;
   assign IRWrite = ir_we  & reset_n;
   assign MemW    = mem_we & reset_n;
   assign RegW    = reg_we & reset_n;
   assign Flags   = flags_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a 3-bit ALUControl instance checked with directed and
// random instructions, then a 2-bit instance checked after a common reset.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       mem_ready = 1'b0;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'd0;
   logic [3:0] Rd = 4'd0, Cond = 4'hE, ALUFlags = 4'd0;

   logic       pcw3, irw3, memw3, regw3, adr3, srca3, ill3;
   logic [1:0] res3, srcb3, imm3, regs3;
   logic [2:0] aluc3;
   logic [3:0] flg3;
   logic       pcw2, irw2, memw2, regw2, adr2, srca2, ill2;
   logic [1:0] res2, srcb2, imm2, regs2;
   logic [1:0] aluc2;
   logic [3:0] flg2;

   always #5 clk = ~clk;

   mc_controller #(.ALU_CTRL_W(3), .RD_W(4)) dut3 (
      .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
      .ALUFlags(ALUFlags), .mem_ready(mem_ready), .PCWrite(pcw3), .IRWrite(irw3),
      .MemW(memw3), .RegW(regw3), .AdrSrc(adr3), .ALUSrcA(srca3), .illegal(ill3),
      .ResultSrc(res3), .ALUSrcB(srcb3), .ImmSrc(imm3), .RegSrc(regs3),
      .ALUControl(aluc3), .Flags(flg3));

   mc_controller #(.ALU_CTRL_W(2), .RD_W(4)) dut2 (
      .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
      .ALUFlags(ALUFlags), .mem_ready(mem_ready), .PCWrite(pcw2), .IRWrite(irw2),
      .MemW(memw2), .RegW(regw2), .AdrSrc(adr2), .ALUSrcA(srca2), .illegal(ill2),
      .ResultSrc(res2), .ALUSrcB(srcb2), .ImmSrc(imm2), .RegSrc(regs2),
      .ALUControl(aluc2), .Flags(flg2));

   wire [17:0] obs3 = {pcw3, irw3, memw3, regw3, adr3, srca3, ill3,
                       res3, srcb3, imm3, regs3, aluc3};
   wire [17:0] obs2 = {pcw2, irw2, memw2, regw2, adr2, srca2, ill2,
                       res2, srcb2, imm2, regs2, 1'b0, aluc2};

   int         total = 0;
   int         bad = 0;
   int         w_sel = 3;
   logic [3:0] mflags = 4'd0;

   localparam logic [3:0] C_AND = 4'b0000, C_EOR = 4'b0001, C_SUB = 4'b0010,
                          C_ADD = 4'b0100, C_CMP = 4'b1010, C_ORR = 4'b1100;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected control vector, field order matching obs3/obs2
   function automatic logic [17:0] vec(input bit pcw, irw, memw, regw, adr, srca, ill,
                                       input logic [1:0] res, srcb, imm, regs,
                                       input logic [2:0] aluc);
      return {pcw, irw, memw, regw, adr, srca, ill, res, srcb, imm, regs, aluc};
   endfunction

   function automatic logic [2:0] alu_code(input logic [3:0] cmd);
      case (cmd)
         C_SUB, C_CMP: return 3'b001;
         C_AND:        return 3'b010;
         C_ORR:        return 3'b011;
         C_EOR:        return 3'b100;
         default:      return 3'b000;
      endcase
   endfunction

   function automatic bit cmd_ok(input int w, input logic [3:0] cmd);
      if (cmd == C_ADD || cmd == C_SUB || cmd == C_AND || cmd == C_ORR) return 1'b1;
      if (cmd == C_EOR || cmd == C_CMP) return (w == 3);
      return 1'b0;
   endfunction

   function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
`ifdef MC_COND_EXEC_EN
      bit n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
`else
      return (c == c) || (f == f);
`endif
   endfunction

   // One clock cycle: drive at the falling edge, check shortly after
   task automatic step(input string tag, input logic [17:0] e, input bit mr, input bit rn = 1'b1);
      logic [17:0] ex;
      @(negedge clk);
      mem_ready = mr;
      reset_n   = rn;
      #1;
      ex = e;
      if (w_sel == 2) begin
         ex[2] = 1'b0;
         chk(tag, 32'(obs2), 32'(ex));
         chk({tag, ".flags"}, 32'(flg2), 32'(mflags));
      end else begin
         chk(tag, 32'(obs3), 32'(ex));
         chk({tag, ".flags"}, 32'(flg3), 32'(mflags));
      end
   endtask

   // Whole instruction as the per-cycle control script it should produce
   task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                            input logic [3:0] cond, input logic [3:0] af,
                            input int fst, input int mst, input bit rst_wr = 1'b0);
      logic [3:0] cmd;
      bit         c, ill, pcrd;
      cmd  = fn[4:1];
      pcrd = (rd == 4'hF);
      @(posedge clk);
      #1;
      Op = op; Funct = fn; Rd = rd; Cond = cond; ALUFlags = af;
      for (int i = 0; i <= fst; i++)
         step("fetch", vec(i == fst, i == fst, 0, 0, 0, 1, 0, 2'd2, 2'd2, 2'd0, 2'd0, 3'd0), i == fst);
      c   = cond_true(cond, mflags);
      ill = c && (op == 2'd3 || (op == 2'd0 && !cmd_ok(w_sel, cmd)));
      step("decode", vec(0, 0, 0, 0, 0, 1, ill, 2'd2, 2'd2, op, {op == 2'd1, op == 2'd2}, 3'd0),
           1'($urandom));
      if (!c || ill) return;
      case (op)
         2'd1: begin
            step("memadr", vec(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0, 3'd0), 1'($urandom));
            if (fn[0]) begin
               for (int i = 0; i <= mst; i++)
                  step("memrd", vec(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0), i == mst);
               step("memwb", vec(pcrd, 0, 0, 1, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0), 1'($urandom));
            end else begin
               for (int i = 0; i <= mst; i++) begin
                  if (rst_wr) begin
                     step("memwr.rst", vec(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0), 1'b0, 1'b0);
                     return;
                  end
                  step("memwr", vec(0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0), i == mst);
               end
            end
         end
         2'd0: begin
            step("exec", vec(0, 0, 0, 0, 0, 0, 0, 2'd0, {1'b0, fn[5]}, 2'd0, 2'd0, alu_code(cmd)),
                 1'($urandom));
            if (fn[0] || cmd == C_CMP) begin
               mflags[3:2] = af[3:2];
               if (cmd == C_ADD || cmd == C_SUB || cmd == C_CMP) mflags[1:0] = af[1:0];
            end
            if (cmd != C_CMP)
               step("aluwb", vec(pcrd, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0), 1'($urandom));
         end
         2'd2: step("branch", vec(1, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 2'd0, 3'd0), 1'($urandom));
         default: ;
      endcase
   endtask

   // Reset held; enables must stay low in FETCH even with mem_ready high
   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      mflags = 4'd0;
      repeat (2) step("reset", vec(0, 0, 0, 0, 0, 1, 0, 2'd2, 2'd2, 2'd0, 2'd0, 3'd0), 1'b1, 1'b0);
   endtask

   task automatic rand_instr(input int n);
      logic [3:0] cmd;
      logic [5:0] fn;
      for (int k = 0; k < n; k++) begin
         case ($urandom_range(0, 7))
            0: cmd = C_ADD; 1: cmd = C_SUB; 2: cmd = C_AND; 3: cmd = C_ORR;
            4: cmd = C_EOR; 5: cmd = C_CMP;
            default: cmd = 4'($urandom);
         endcase
         fn = {1'($urandom), cmd, 1'($urandom)};
         run_instr(2'($urandom), fn, 4'($urandom), 4'($urandom), 4'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 3));
      end
   endtask

   initial begin
      do_reset();
      // ADD r3 (no S), LDR with 3 stall cycles, SUBS to PC
      run_instr(2'd0, {1'b0, C_ADD, 1'b0}, 4'd3, 4'hE, 4'hF, 0, 0);
      run_instr(2'd1, 6'b000001, 4'd5, 4'hE, 4'h0, 0, 3);
      run_instr(2'd0, {1'b0, C_SUB, 1'b1}, 4'd15, 4'hE, 4'b0110, 1, 0);
      run_instr(2'd1, 6'b000000, 4'd2, 4'hE, 4'h0, 2, 2);
      run_instr(2'd2, 6'b100000, 4'd0, 4'hE, 4'h0, 0, 0);
      run_instr(2'd3, 6'b000000, 4'd1, 4'hE, 4'h0, 0, 0);
      run_instr(2'd0, {1'b0, C_CMP, 1'b0}, 4'd4, 4'hE, 4'b1001, 0, 0);
      run_instr(2'd0, {1'b1, C_EOR, 1'b1}, 4'd6, 4'hE, 4'b0111, 0, 0);
      run_instr(2'd0, {1'b0, 4'b0111, 1'b1}, 4'd6, 4'hE, 4'b1111, 0, 0);
      run_instr(2'd1, 6'b000001, 4'd15, 4'hE, 4'h0, 0, 1);
      rand_instr(250);
      // Reset landing in the middle of a store stall
      run_instr(2'd0, {1'b0, C_ADD, 1'b1}, 4'd1, 4'hE, 4'b1010, 0, 0);
      run_instr(2'd1, 6'b000000, 4'd7, 4'hE, 4'h0, 0, 2, 1'b1);
      mflags = 4'd0;
      step("rst.fetch", vec(0, 0, 0, 0, 0, 1, 0, 2'd2, 2'd2, 2'd0, 2'd0, 3'd0), 1'b1, 1'b0);
      rand_instr(20);

      // Narrow ALUControl instance
      w_sel = 2;
      do_reset();
      run_instr(2'd0, {1'b0, C_EOR, 1'b1}, 4'd3, 4'hE, 4'hF, 0, 0);
      run_instr(2'd0, {1'b0, C_CMP, 1'b1}, 4'd3, 4'hE, 4'hF, 0, 0);
      run_instr(2'd0, {1'b1, C_ORR, 1'b1}, 4'd9, 4'hE, 4'b1011, 0, 0);
      run_instr(2'd0, {1'b0, C_SUB, 1'b0}, 4'd15, 4'hE, 4'b0101, 0, 0);
      rand_instr(80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ALU_CTRL_W, default 3, ALUControl width; legal values 2 or 3.
REQ-002 Parameter RD_W, default 4, destination-register field width; the PC register index is all-ones.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset is synchronous and active-low.
REQ-005 Op  in  2  instruction class (00 data-processing, 01 memory, 10 branch, 11 undefined).
REQ-006 Funct  in  6  instr bits [25:20]: I, cmd[3:0], S/L.
REQ-007 Rd  in  RD_W  destination register.
REQ-008 Cond  in  4  condition field.
REQ-009 ALUFlags  in  4  NZCV from ALU, sampled in execute states.
REQ-010 mem_ready  in  1  memory completion; low stalls memory states.
REQ-011 Outputs, 1 bit each: PCWrite, IRWrite, MemW, RegW, AdrSrc, ALUSrcA, illegal.
REQ-012 Outputs, 2 bits each: ResultSrc, ALUSrcB, ImmSrc, RegSrc.
REQ-013 ALUControl  out  ALU_CTRL_W  ALU operation.
REQ-014 Flags  out  4  architectural NZCV register.

Function
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, with FETCH following reset.
REQ-016 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD; IRWrite=PCWrite=mem_ready; holds until mem_ready=1, then DECODE.
REQ-017 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, RegSrc and ImmSrc from Op.
REQ-018 DECODE transitions:
- condition false: FETCH
- Op=01: MEMADR
- Op=00 with I=1: EXECI
- Op=00 with I=0: EXECR
- Op=10: BRANCH
- Op=11: FETCH, with illegal=1 for that one cycle.
REQ-019 MEMADR: ALUSrcB=01, ALUControl=ADD; L=1 goes to MEMRD, L=0 goes to MEMWR.
REQ-020 MEMRD: AdrSrc=1; holds until mem_ready=1, then MEMWB. MEMWB: ResultSrc=01, RegW=1, then FETCH.
REQ-021 MEMWR: AdrSrc=1, MemW=1 while waiting; leaves for FETCH on the cycle mem_ready=1.
REQ-022 EXECR uses ALUSrcB=00; EXECI uses ALUSrcB=01.
REQ-023 From EXECR or EXECI, go to ALUWB, except CMP goes directly to FETCH.
REQ-024 ALUWB: ResultSrc=00, RegW=1, then FETCH.
REQ-025 BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=1, then FETCH.
REQ-026 In MEMWB or ALUWB with Rd all-ones, PCWrite=1 in the same cycle as RegW.
REQ-027 ALUControl encoding in execute states: ADD(0100)=000, SUB(0010)=001, AND(0000)=010, ORR(1100)=011.
REQ-028 With ALU_CTRL_W=3, EOR(0001)=100 and CMP(1010)=001 are also decoded; CMP also forces FlagW.
REQ-029 Any other cmd, or EOR/CMP when ALU_CTRL_W=2, goes to FETCH from DECODE with illegal=1 and no writes.
REQ-030 Flags update, only in EXECR or EXECI, from ALUFlags:
- NZ updates when S=1.
- CV updates when S=1 and the operation is ADD, SUB or CMP.
REQ-031 Outputs not listed for a state are 0, except ALUControl, which defaults to ADD.
REQ-032 A memory write to the PC (STR with Rd all-ones) is not special-cased.

Reset
REQ-033 reset_n=0 at a rising edge forces state to FETCH and Flags to 0000.
REQ-034 During reset all write enables (PCWrite, IRWrite, MemW, RegW) are 0 regardless of mem_ready, including when reset occurs mid-stall.
REQ-035 The first FETCH follows the first edge with reset_n=1.

Configuration
REQ-036 Macro MC_COND_EXEC_EN defined: the condition evaluates from Cond and Flags using the standard EQ..LE table, with 1110 and 1111 true.
REQ-037 Macro MC_COND_EXEC_EN defined: when the condition is false, DECODE goes to FETCH, Flags do not update, and there are no writes.
REQ-038 Macro MC_COND_EXEC_EN undefined: the condition is always true, and Cond is unused.

Verification
REQ-039 ADD with S=0, Rd=3, mem_ready=1: FETCH, DECODE, EXECR, ALUWB, FETCH; RegW=1 only in ALUWB; ALUControl=000.
REQ-040 LDR with mem_ready low 3 cycles in MEMRD: state held 3 extra cycles with no RegW, then MEMWB with ResultSrc=01.
REQ-041 SUBS, ALUFlags=0110, Rd=15: Flags=0110 after EXECR; PCWrite=RegW=1 in ALUWB.
REQ-042 MC_COND_EXEC_EN, Flags Z=0, BEQ: DECODE goes to FETCH, no PCWrite beyond fetch; with Z=1, BRANCH asserts PCWrite.
REQ-043 ALU_CTRL_W=2, EOR cmd: illegal=1 for 1 cycle, then FETCH, no RegW.
REQ-044 reset_n=0 during a MEMWR stall: next cycle is FETCH with MemW=0 and Flags=0000.
